// File: rtl/audio_mixer.sv
// Stereo Paula mixer feeding the sigma-delta modulator: one shared multiplier
// steps through the four channels, ch0+ch3 to the left sum, ch1+ch2 to the right.
//
// state | meaning
// IDLE  | waiting for sample_en
// CH0   | scale ch0, add to left accumulator
// CH1   | scale ch1, add to right accumulator
// CH2   | scale ch2, add to right accumulator
// CH3   | scale ch3, add to left accumulator
// UPD   | publish sums, pulse mix_valid; a strobe here restarts at CH0
module audio_mixer #(
   parameter int SW   = 8,
   parameter int VW   = 7,
   parameter int VMAX = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    sample_en,
   input  logic signed [SW-1:0]    aud0,
   input  logic signed [SW-1:0]    aud1,
   input  logic signed [SW-1:0]    aud2,
   input  logic signed [SW-1:0]    aud3,
   input  logic        [VW-1:0]    vol0,
   input  logic        [VW-1:0]    vol1,
   input  logic        [VW-1:0]    vol2,
   input  logic        [VW-1:0]    vol3,
   input  logic        [3:0]       chan_en,
   output logic signed [SW+VW-1:0] ldatasum,
   output logic signed [SW+VW-1:0] rdatasum,
   output logic                    mix_valid,
   output logic                    busy,
   output logic                    overrun
);

   localparam int OW = SW + VW;
   localparam logic [VW-1:0] VMAX_V = VW'(VMAX);

   typedef enum logic [2:0] {IDLE, CH0, CH1, CH2, CH3, UPD} state_t;

   state_t                state;
   logic signed [SW-1:0]  aud_snap [4];
   logic        [VW-1:0]  vol_snap [4];
   logic        [3:0]     en_snap;
   logic signed [OW-1:0]  accl;
   logic signed [OW-1:0]  accr;
   logic        [1:0]     ch_idx;
   logic signed [OW-1:0]  prod;
   logic                  accept;

   function automatic logic [VW-1:0] clamp_vol(input logic [VW-1:0] v);
      return (v > VMAX_V) ? VMAX_V : v;
   endfunction

   assign accept = sample_en && (state == IDLE || state == UPD);

   always_comb begin
      ch_idx = 2'd0;
      case (state)
         CH1:     ch_idx = 2'd1;
         CH2:     ch_idx = 2'd2;
         CH3:     ch_idx = 2'd3;
         default: ch_idx = 2'd0;
      endcase
   end

   // Both operands widened to OW so the product is exact; the clamp keeps it in range.
   always_comb begin
      prod = '0;
      if (en_snap[ch_idx])
         prod = $signed({{VW{aud_snap[ch_idx][SW-1]}}, aud_snap[ch_idx]})
              * $signed({{SW{1'b0}}, vol_snap[ch_idx]});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ldatasum  <= '0;
         rdatasum  <= '0;
         accl      <= '0;
         accr      <= '0;
         mix_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         en_snap   <= '0;
         for (int i = 0; i < 4; i++) begin
            aud_snap[i] <= '0;
            vol_snap[i] <= '0;
         end
      end else begin
         mix_valid <= 1'b0;
         if (accept) begin
            aud_snap[0] <= aud0;
            aud_snap[1] <= aud1;
            aud_snap[2] <= aud2;
            aud_snap[3] <= aud3;
            vol_snap[0] <= clamp_vol(vol0);
            vol_snap[1] <= clamp_vol(vol1);
            vol_snap[2] <= clamp_vol(vol2);
            vol_snap[3] <= clamp_vol(vol3);
            en_snap     <= chan_en;
            accl        <= '0;
            accr        <= '0;
         end else if (sample_en) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= CH0;
                  busy  <= 1'b1;
               end
            end
            CH0: begin
               accl  <= accl + prod;
               state <= CH1;
            end
            CH1: begin
               accr  <= accr + prod;
               state <= CH2;
            end
            CH2: begin
               accr  <= accr + prod;
               state <= CH3;
            end
            CH3: begin
               accl  <= accl + prod;
               state <= UPD;
               busy  <= 1'b0;
            end
            UPD: begin
               ldatasum  <= accl;
               rdatasum  <= accr;
               mix_valid <= 1'b1;
               state     <= accept ? CH0 : IDLE;
               busy      <= accept;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: directed cases plus random mixes, checked every cycle
// against an arithmetic model and a queue of expected mix results.
module tb_audio_mixer;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              sample_en = 1'b0;
   logic signed [7:0] aud [4];
   logic        [6:0] vol [4];
   logic        [3:0] chan_en;
   logic signed [14:0] ldatasum;
   logic signed [14:0] rdatasum;
   logic              mix_valid;
   logic              busy;
   logic              overrun;

   typedef struct {int l; int r; int c;} exp_t;
   exp_t q[$];
   exp_t e_mon;
   exp_t e_new;

   int cyc = 0;
   int last_acc = -100;
   int ov_cyc = 1 << 30;
   int cur_l = 0;
   int cur_r = 0;
   int nvec = 0;
   int nerr = 0;
   int d_mon;

   audio_mixer dut (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
      .aud0(aud[0]), .aud1(aud[1]), .aud2(aud[2]), .aud3(aud[3]),
      .vol0(vol[0]), .vol1(vol[1]), .vol2(vol[2]), .vol3(vol[3]),
      .chan_en(chan_en), .ldatasum(ldatasum), .rdatasum(rdatasum),
      .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_val(input string tag, input int obs, input int exp);
      nvec++;
      if (obs != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int term(input int a, input int v, input bit e);
      int vc;
      vc = (v > 64) ? 64 : v;
      return e ? a * vc : 0;
   endfunction

   always @(negedge clk) begin
      if (mix_valid) begin
         if (q.size() == 0) chk_val("spurious_mix_valid", 1, 0);
         else begin
            e_mon = q.pop_front();
            chk_val("latency", cyc - e_mon.c, 5);
            cur_l = e_mon.l;
            cur_r = e_mon.r;
         end
      end
      d_mon = cyc - last_acc;
      chk_val("ldatasum", int'(ldatasum), cur_l);
      chk_val("rdatasum", int'(rdatasum), cur_r);
      chk_val("busy", int'(busy), (d_mon >= 0 && d_mon <= 3) ? 1 : 0);
      chk_val("overrun", int'(overrun), (cyc >= ov_cyc) ? 1 : 0);
   end

   task automatic rand_inputs();
      for (int i = 0; i < 4; i++) begin
         aud[i] = 8'($urandom);
         vol[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(65, 127))
                                              : 7'($urandom_range(0, 64));
      end
      chan_en = 4'($urandom);
   endtask

   task automatic set_inputs(input int a0, input int a1, input int a2, input int a3,
                             input int v0, input int v1, input int v2, input int v3,
                             input logic [3:0] en);
      aud[0] = 8'(a0); aud[1] = 8'(a1); aud[2] = 8'(a2); aud[3] = 8'(a3);
      vol[0] = 7'(v0); vol[1] = 7'(v1); vol[2] = 7'(v2); vol[3] = 7'(v3);
      chan_en = en;
   endtask

   // Called at a negedge; the strobe is sampled by the following posedge.
   task automatic strobe();
      sample_en = 1'b1;
      e_new.l = term(int'(aud[0]), int'(vol[0]), chan_en[0])
              + term(int'(aud[3]), int'(vol[3]), chan_en[3]);
      e_new.r = term(int'(aud[1]), int'(vol[1]), chan_en[1])
              + term(int'(aud[2]), int'(vol[2]), chan_en[2]);
      e_new.c = cyc + 1;
      q.push_back(e_new);
      last_acc = cyc + 1;
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   task automatic drop();
      sample_en = 1'b1;
      if (ov_cyc > cyc + 1) ov_cyc = cyc + 1;
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input bit scramble);
      for (int k = 0; k < n; k++) begin
         if (scramble) rand_inputs();
         @(negedge clk);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 20; k++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      chk_val("drain_pending", q.size(), 0);
   endtask

   task automatic do_mix(input int gap);
      strobe();
      idle_cycles(gap - 1, 1'b1);
   endtask

   initial begin
      int gap;
      int drop_at;
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
      repeat (3) @(negedge clk);
      chk_val("rst_mix_valid", int'(mix_valid), 0);
      chk_val("rst_ldatasum", int'(ldatasum), 0);
      reset_n = 1'b1;
      @(negedge clk);

      set_inputs(0, 0, 0, 0, 64, 64, 64, 64, 4'hF);
      do_mix(8);
      set_inputs(127, 0, 0, 0, 64, 0, 0, 0, 4'hF);
      do_mix(8);
      set_inputs(-128, 127, 127, -128, 64, 64, 64, 64, 4'hF);
      do_mix(8);
      set_inputs(0, -1, 0, 0, 0, 100, 0, 0, 4'hF);
      do_mix(6);
      set_inputs(0, -1, 0, 0, 0, 100, 0, 0, 4'hD);
      do_mix(6);
      drain();

      // second strobe lands in CH1 and must be ignored
      set_inputs(100, -50, 33, -7, 64, 40, 127, 10, 4'hF);
      strobe();
      idle_cycles(1, 1'b1);
      drop();
      idle_cycles(4, 1'b1);
      drain();
      chk_val("overrun_sticky", int'(overrun), 1);
      rand_inputs();
      do_mix(7);
      drain();

      // back-to-back mixes, then reset while the last one is in CH2
      for (int k = 0; k < 3; k++) begin
         rand_inputs();
         do_mix(5);
      end
      rand_inputs();
      strobe();
      idle_cycles(2, 1'b1);
      #2 reset_n = 1'b0;
      void'(q.pop_back());
      last_acc = -100;
      ov_cyc = 1 << 30;
      cur_l = 0;
      cur_r = 0;
      #1;
      chk_val("rst_mid_ldatasum", int'(ldatasum), 0);
      chk_val("rst_mid_rdatasum", int'(rdatasum), 0);
      chk_val("rst_mid_busy", int'(busy), 0);
      chk_val("rst_mid_overrun", int'(overrun), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      set_inputs(127, -128, 5, 127, 64, 127, 64, 64, 4'hF);
      do_mix(6);
      drain();

      for (int n = 0; n < 40; n++) begin
         rand_inputs();
         gap = $urandom_range(5, 8);
         drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         strobe();
         for (int k = 1; k < gap; k++) begin
            if (k == drop_at) drop();
            else idle_cycles(1, 1'b1);
         end
      end
      drain();
      idle_cycles(3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
